// File: rtl/sdp_scan_driver.sv
// Multiplexed seven-segment scanner: frame-snapshotted nibbles, blank gap between digits, per-digit enable/dp.
// Optional brightness PWM in SHOW when SDP_DIM_EN is defined (adds the 'bright' input).
module sdp_scan_driver #(
    parameter int unsigned DIGITS  = 8,
    parameter int unsigned ON_CYC  = 100000,
    parameter int unsigned GAP_CYC = 1000,
    localparam int unsigned SEL_W  = $clog2(DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef SDP_DIM_EN
    input  logic [3:0]            bright,
`endif
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     en,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic [SEL_W-1:0]      digit_idx,
    output logic                  frame_tick
);

    localparam int unsigned CNT_MAX = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SEL_W-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0]  data_sh_q, data_sh_d;
    logic [DIGITS-1:0]    dp_sh_q, dp_sh_d;
    logic [DIGITS-1:0]    en_sh_q, en_sh_d;
    logic [DIGITS-1:0]    an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_n_q, dp_n_d;
    logic                 frame_tick_q, frame_tick_d;
    logic                 drive_ok;

    // Active-low hex decode, segment order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

`ifdef SDP_DIM_EN
    logic [3:0] pwm_q, pwm_d;
    assign pwm_d    = pwm_q + 4'd1;
    assign drive_ok = (pwm_q <= bright);
`else
    assign drive_ok = 1'b1;
`endif

    // Next-state: slot sequencing, frame snapshot, and registered display drive
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        data_sh_d    = data_sh_q;
        dp_sh_d      = dp_sh_q;
        en_sh_d      = en_sh_q;
        frame_tick_d = 1'b0;
        an_d         = '1;
        seg_d        = 7'h7F;
        dp_n_d       = 1'b1;

        if (state_q == SHOW) begin
            if (cnt_q == CNT_W'(ON_CYC - 1)) begin
                state_d = GAP;
                cnt_d   = '0;
            end
        end else begin
            if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                state_d = SHOW;
                cnt_d   = '0;
                if (idx_q == SEL_W'(DIGITS - 1)) begin
                    idx_d        = '0;
                    data_sh_d    = data;
                    dp_sh_d      = dp;
                    en_sh_d      = en;
                    frame_tick_d = 1'b1;
                end else begin
                    idx_d = idx_q + SEL_W'(1);
                end
            end
        end

        // Disabled digits still consume their slot so the duty stays uniform
        if (state_q == SHOW && drive_ok) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (idx_q == SEL_W'(i) && en_sh_q[i]) begin
                    an_d[i] = 1'b0;
                    seg_d   = hex_to_seg(data_sh_q[4*i +: 4]);
                    dp_n_d  = ~dp_sh_q[i];
                end
            end
        end
    end

    // Reset parks in the last GAP cycle of the last digit so release triggers the wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= GAP;
            cnt_q        <= CNT_W'(GAP_CYC - 1);
            idx_q        <= SEL_W'(DIGITS - 1);
            data_sh_q    <= '0;
            dp_sh_q      <= '0;
            en_sh_q      <= '0;
            an_q         <= '1;
            seg_q        <= 7'h7F;
            dp_n_q       <= 1'b1;
            frame_tick_q <= 1'b0;
`ifdef SDP_DIM_EN
            pwm_q        <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            data_sh_q    <= data_sh_d;
            dp_sh_q      <= dp_sh_d;
            en_sh_q      <= en_sh_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_n_q       <= dp_n_d;
            frame_tick_q <= frame_tick_d;
`ifdef SDP_DIM_EN
            pwm_q        <= pwm_d;
`endif
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp_n       = dp_n_q;
    assign frame_tick = frame_tick_q;
    assign digit_idx  = idx_q;

endmodule

// File: tb/tb_sdp_scan_driver.sv
// Scoreboard bench for sdp_scan_driver (DIGITS=4, ON_CYC=4, GAP_CYC=2): timeline model pushes, negedge monitor compares.
module tb_sdp_scan_driver;

    localparam int D     = 4;
    localparam int ON    = 4;
    localparam int GAP   = 2;
    localparam int SLOT  = ON + GAP;
    localparam int FRAME = D * SLOT;
    localparam int IW    = 2;

    typedef struct packed {
        logic [D-1:0]  an;
        logic [6:0]    seg;
        logic          dp_n;
        logic          ft;
        logic [IW-1:0] idx;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [4*D-1:0]  data;
    logic [D-1:0]    dp;
    logic [D-1:0]    en;
    logic [D-1:0]    an;
    logic [6:0]      seg;
    logic            dp_n;
    logic [IW-1:0]   digit_idx;
    logic            frame_tick;
`ifdef SDP_DIM_EN
    logic [3:0]      bright = 4'hF;
`endif

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   done        = 1'b0;

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    sdp_scan_driver #(.DIGITS(D), .ON_CYC(ON), .GAP_CYC(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef SDP_DIM_EN
        .bright     (bright),
`endif
        .data       (data),
        .dp         (dp),
        .en         (en),
        .an         (an),
        .seg        (seg),
        .dp_n       (dp_n),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Timeline model: k counts edges since reset release; frame starts at k=1, display lags idx by one clock
    int             k = 0;
    logic [4*D-1:0] sh_data = '0;
    logic [D-1:0]   sh_dp   = '0;
    logic [D-1:0]   sh_en   = '0;

    always @(posedge clk) begin
        exp_t e;
        int   p, s;
        e.an   = '1;
        e.seg  = 7'h7F;
        e.dp_n = 1'b1;
        e.ft   = 1'b0;
        if (rst) begin
            k     = 0;
            e.idx = IW'(D - 1);
        end else begin
            k++;
            e.ft  = (((k - 1) % FRAME) == 0);
            e.idx = IW'(((k - 1) % FRAME) / SLOT);
            if (k >= 2) begin
                p = (k - 2) % FRAME;
                s = p / SLOT;
                if ((p % SLOT) < ON && sh_en[s]) begin
                    e.an[s] = 1'b0;
                    e.seg   = seg_tbl[sh_data[4*s +: 4]];
                    e.dp_n  = ~sh_dp[s];
                end
            end
            if (e.ft) begin
                sh_data = data;
                sh_dp   = dp;
                sh_en   = en;
            end
        end
        q.push_back(e);
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if (an !== e.an || seg !== e.seg || dp_n !== e.dp_n || frame_tick !== e.ft ||
                digit_idx !== e.idx || $countones(~an) > 1) begin
                miscompares++;
                $display("FAIL scan t=%0t an=%b/%b seg=%h/%h dp_n=%b/%b tick=%b/%b idx=%0d/%0d (got/exp)",
                         $time, an, e.an, seg, e.seg, dp_n, e.dp_n, frame_tick, e.ft, digit_idx, e.idx);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        data = 16'h3210;
        en   = 4'hF;
        dp   = 4'h0;
        cycles(3);
        rst = 1'b0;
        cycles(9);                 // into slot 1 of frame 0
        data = 16'hFEDC;           // must not appear until frame 1
        cycles(20);
        en = 4'b1010;
        dp = 4'b0010;
        cycles(50);
        // Reset mid-SHOW of digit 2
        cycles(FRAME - ((k - 1) % FRAME) + 2 * SLOT + 2);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        en  = 4'hF;
        cycles(30);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                data = 16'($urandom);
                dp   = 4'($urandom);
                en   = 4'($urandom);
            end
            rst = ($urandom_range(0, 150) == 0);
            cycles(1);
        end
        rst = 1'b0;
        cycles(2 * FRAME);
        done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        while (!done && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        if (!done) begin
            miscompares++;
            $display("FAIL timeout stimulus not finished after %0d cycles", budget);
        end
        cycles(2);
        if (vectors < 100) begin
            miscompares++;
            $display("FAIL coverage vectors=%0d required>=100", vectors);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
